// File: rtl/dmem_pkg.sv
// Shared types and constants for the MEM-stage data memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam logic RW_WRITE  = 1'b1;
    localparam logic RW_READ   = 1'b0;
    localparam logic SIZE_BYTE = 1'b1;
    localparam logic SIZE_WORD = 1'b0;

    localparam int CNT_W = 4;

    // A byte access only touches the lane that maps to address a (the MSB lane).
    function automatic logic [3:0] lane_enables(input logic size);
        return (size == SIZE_BYTE) ? 4'b1000 : 4'b1111;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Byte-wide storage, big-endian lane mapping: lane 3 holds byte a, lane 0 holds byte a+3.
module dmem_array #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [3:0]            be,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [7:0] mem [2**ADDR_WIDTH];

    // Addresses wrap naturally through ADDR_WIDTH-bit arithmetic.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[3-i]) begin
                    mem[addr + ADDR_WIDTH'(i)] <= wdata[31-8*i -: 8];
                end
            end
        end
    end

    assign rdata = {mem[addr],
                    mem[addr + ADDR_WIDTH'(1)],
                    mem[addr + ADDR_WIDTH'(2)],
                    mem[addr + ADDR_WIDTH'(3)]};

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data memory responder: latches a request, waits WAIT_STATES cycles,
// performs the access and returns a one-cycle ready pulse while stalling the pipe.
module data_mem_responder #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m_enable,
    input  logic        m_rw,
    input  logic        m_size,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        m_busy,
    output logic        m_ready,
    output logic        err
);

    import dmem_pkg::*;

    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_STATES);

    state_t state, state_next;
    logic [CNT_W-1:0] cnt;

    logic [ADDR_WIDTH-1:0] lat_addr;
    logic                  lat_rw;
    logic                  lat_size;
    logic [31:0]           lat_data;

    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  req_rw;
    logic                  req_size;
    logic [31:0]           req_data;

    logic        accept;
    logic        do_access;
    logic        misaligned;
    logic        wr_en;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;
    logic [31:0] rd_word;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^addr[31:ADDR_WIDTH];

    assign accept = (state == IDLE) && m_enable;
    assign m_busy = accept || (state == WAIT);

    // With zero wait states the access happens on the accept edge, so the
    // live inputs must be used there instead of the not-yet-loaded latches.
    assign req_addr = (state == IDLE) ? addr[ADDR_WIDTH-1:0] : lat_addr;
    assign req_rw   = (state == IDLE) ? m_rw                 : lat_rw;
    assign req_size = (state == IDLE) ? m_size               : lat_size;
    assign req_data = (state == IDLE) ? data_in              : lat_data;

    assign misaligned = (req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00);
    assign wr_en      = do_access && (req_rw == RW_WRITE) && !misaligned;
    assign wr_be      = lane_enables(req_size);
    assign wr_data    = (req_size == SIZE_BYTE) ? {req_data[7:0], 24'h0} : req_data;

    always_comb begin
        state_next = state;
        do_access  = 1'b0;
        case (state)
            IDLE: begin
                if (m_enable) begin
                    if (WAIT_STATES == 0) begin
                        state_next = RESP;
                        do_access  = 1'b1;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == CNT_W'(1)) begin
                    state_next = RESP;
                    do_access  = 1'b1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            lat_addr <= '0;
            lat_rw   <= 1'b0;
            lat_size <= 1'b0;
            lat_data <= '0;
        end else if (accept) begin
            cnt      <= WAIT_LOAD;
            lat_addr <= addr[ADDR_WIDTH-1:0];
            lat_rw   <= m_rw;
            lat_size <= m_size;
            lat_data <= data_in;
        end else if (state == WAIT) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // data_out only moves on read or error responses; writes leave it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ready  <= 1'b0;
            err      <= 1'b0;
            data_out <= '0;
        end else begin
            m_ready <= do_access;
            if (do_access) begin
                if (misaligned) begin
                    err      <= 1'b1;
                    data_out <= '0;
                end else begin
                    err <= 1'b0;
                    if (req_rw == RW_READ) begin
                        data_out <= (req_size == SIZE_BYTE) ? {24'h0, rd_word[31:24]} : rd_word;
                    end
                end
            end
        end
    end

    dmem_array #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_array (
        .clk   (clk),
        .we    (wr_en),
        .be    (wr_be),
        .addr  (req_addr),
        .wdata (wr_data),
        .rdata (rd_word)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: a byte-array reference model drives expectations for a
// WAIT_STATES=2 instance, plus a zero-wait instance for back-to-back traffic.
module tb_data_mem_responder;

    localparam int AW = 8;
    localparam int WS = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m_enable, m_rw, m_size;
    logic [31:0] addr, data_in;
    logic [31:0] data_out;
    logic        m_busy, m_ready, err;

    logic        en0, rw0, sz0;
    logic [31:0] addr0, din0;
    logic [31:0] dout0;
    logic        busy0, rdy0, err0;

    int checks = 0;
    int errors = 0;

    logic [7:0]  model [256];
    logic [31:0] model_dout;

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(WS)) dut (
        .clk(clk), .rst_n(rst_n), .m_enable(m_enable), .m_rw(m_rw), .m_size(m_size),
        .addr(addr), .data_in(data_in), .data_out(data_out), .m_busy(m_busy),
        .m_ready(m_ready), .err(err)
    );

    data_mem_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .m_enable(en0), .m_rw(rw0), .m_size(sz0),
        .addr(addr0), .data_in(din0), .data_out(dout0), .m_busy(busy0),
        .m_ready(rdy0), .err(err0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [7:0] a);
        return {model[a], model[a + 8'd1], model[a + 8'd2], model[a + 8'd3]};
    endfunction

    // One full transaction on the WAIT_STATES=2 instance, starting in an IDLE cycle.
    task automatic run_req(input logic rw, input logic size, input logic [31:0] a, input logic [31:0] d);
        logic [7:0]  ab;
        logic        mis;
        logic [31:0] exp_dout;
        ab       = a[7:0];
        mis      = (size == 1'b0) && (ab[1:0] != 2'b00);
        exp_dout = model_dout;
        if (mis) begin
            exp_dout = 32'h0;
        end else if (rw) begin
            if (size) model[ab] = d[7:0];
            else for (int i = 0; i < 4; i++) model[ab + 8'(i)] = d[31-8*i -: 8];
        end else begin
            exp_dout = size ? {24'h0, model[ab]} : model_word(ab);
        end
        model_dout = exp_dout;

        m_enable = 1'b1; m_rw = rw; m_size = size; addr = a; data_in = d;
        #1;
        check("busy_accept", 32'(m_busy), 32'd1);
        @(posedge clk); #1;
        m_enable = 1'($urandom); m_rw = 1'($urandom); m_size = 1'($urandom);
        addr = $urandom; data_in = $urandom;
        for (int c = 1; c <= WS + 1; c++) begin
            check("ready_latency", 32'(m_ready), 32'(c == WS + 1));
            check("busy_wait", 32'(m_busy), 32'(c <= WS));
            if (c <= WS) begin
                @(posedge clk); #1;
            end
        end
        check("resp_data", data_out, exp_dout);
        check("resp_err", 32'(err), 32'(mis));
        m_enable = 1'b1;
        @(posedge clk); #1;
        m_enable = 1'b0;
        #1;
        check("ready_pulse", 32'(m_ready), 32'd0);
        check("no_accept_in_resp", 32'(m_busy), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] w [4];
        logic [31:0] a;

        rst_n = 1'b1;
        m_enable = 1'b0; m_rw = 1'b0; m_size = 1'b0; addr = '0; data_in = '0;
        en0 = 1'b0; rw0 = 1'b0; sz0 = 1'b0; addr0 = '0; din0 = '0;
        model_dout = 32'h0;
        #2 rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("rst_data_out", data_out, 32'h0);
        check("rst_ready", 32'(m_ready), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_busy", 32'(m_busy), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Zero-wait instance: m_enable held high, ready every second cycle.
        for (int i = 0; i < 4; i++) w[i] = $urandom;
        en0 = 1'b1;
        for (int k = 0; k < 9; k++) begin
            if (k < 4) begin
                rw0 = 1'b1; sz0 = 1'b0; addr0 = 32'h40 + 32'(4 * k); din0 = w[k];
            end else if (k < 8) begin
                rw0 = 1'b0; sz0 = 1'b0; addr0 = 32'h40 + 32'(4 * (k - 4)); din0 = $urandom;
            end else begin
                rw0 = 1'b0; sz0 = 1'b1; addr0 = 32'h41; din0 = $urandom;
            end
            #1;
            check("ws0_idle_busy", 32'(busy0), 32'd1);
            check("ws0_idle_ready", 32'(rdy0), 32'd0);
            @(posedge clk); #1;
            check("ws0_resp_ready", 32'(rdy0), 32'd1);
            check("ws0_resp_busy", 32'(busy0), 32'd0);
            if (k < 4)      check("ws0_store_hold", dout0, 32'h0);
            else if (k < 8) check("ws0_load", dout0, w[k - 4]);
            else            check("ws0_byte_load", dout0, {24'h0, w[0][23:16]});
            check("ws0_err", 32'(err0), 32'd0);
            @(posedge clk);
        end
        #1 en0 = 1'b0;
        @(posedge clk); #1;

        // Give every byte a known value.
        for (int i = 0; i < 64; i++) run_req(1'b1, 1'b0, 32'(4 * i), $urandom);

        run_req(1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
        run_req(1'b0, 1'b0, 32'h10, 32'h0);
        check("tp_word_load", data_out, 32'hDEADBEEF);
        run_req(1'b0, 1'b1, 32'h11, 32'h0);
        check("tp_byte_load", data_out, 32'h000000AD);
        run_req(1'b1, 1'b1, 32'h12, 32'hFFFFFF55);
        run_req(1'b0, 1'b0, 32'h10, 32'h0);
        check("tp_byte_store", data_out, 32'hDEAD55EF);
        run_req(1'b0, 1'b0, 32'h13, 32'h0);
        check("tp_misaligned_err", 32'(err), 32'd1);
        check("tp_misaligned_data", data_out, 32'h0);
        run_req(1'b1, 1'b0, 32'h11, 32'hCAFEBABE);
        run_req(1'b0, 1'b0, 32'h10, 32'h0);
        check("tp_misaligned_store", data_out, 32'hDEAD55EF);
        run_req(1'b1, 1'b0, 32'h104, 32'hA5A51234);
        run_req(1'b0, 1'b0, 32'h04, 32'h0);
        check("tp_wrap", data_out, 32'hA5A51234);

        // Reset in the WAIT phase of a store must discard it.
        m_enable = 1'b1; m_rw = 1'b1; m_size = 1'b0; addr = 32'h20; data_in = 32'h12345678;
        @(posedge clk); #1;
        m_enable = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_ready", 32'(m_ready), 32'd0);
        check("midrst_busy", 32'(m_busy), 32'd0);
        check("midrst_data", data_out, 32'h0);
        @(posedge clk); @(posedge clk); #1;
        check("midrst_ready_hold", 32'(m_ready), 32'd0);
        rst_n = 1'b1;
        model_dout = 32'h0;
        @(posedge clk); #1;
        run_req(1'b0, 1'b0, 32'h20, 32'h0);

        for (int n = 0; n < 80; n++) begin
            a = $urandom;
            if ($urandom_range(1, 0) == 1) a[1:0] = 2'b00;
            run_req(1'($urandom), 1'($urandom), a, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
